// File: rtl/hc_sr04_pkg.sv
// Shared types and default timing constants for the HC-SR04 measurement sequencer.
package hc_sr04_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEAS      = 3'd3,
        FAIL      = 3'd4,
        HOLD      = 3'd5
    } state_e;

    localparam int DEF_CLKS_PER_US = 50;
    localparam int DEF_TRIG_US     = 10;
    localparam int DEF_US_PER_CM   = 58;
    localparam int DEF_TIMEOUT_US  = 38000;
    localparam int DEF_HOLDOFF_US  = 60000;
    localparam int DEF_DIST_W      = 16;

    // Width of the microsecond and holdoff counters: room for the larger limit plus one bit.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/hc_sr04_us_tick.sv
// Microsecond prescaler: counts 0..CLKS_PER_US-1 and pulses us_tick_o on the last count.
// clr_i restarts the count so an interval measured from the clear is an exact number of µs.
module hc_sr04_us_tick #(
    parameter int CLKS_PER_US = 50
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic us_tick_o
);

    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLKS_PER_US - 1);

    logic [PW-1:0] cnt_q;

    assign us_tick_o = (cnt_q == LAST);

    // Prescaler count with synchronous reset/clear and wrap on the last count.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/hc_sr04_ctrl.sv
// HC-SR04 measurement sequencer: trigger pulse, echo timing, cm conversion by
// counting whole US_PER_CM intervals, timeout and minimum cycle time enforcement.
module hc_sr04_ctrl
    import hc_sr04_pkg::*;
#(
    parameter int CLKS_PER_US = DEF_CLKS_PER_US,
    parameter int TRIG_US     = DEF_TRIG_US,
    parameter int US_PER_CM   = DEF_US_PER_CM,
    parameter int TIMEOUT_US  = DEF_TIMEOUT_US,
    parameter int HOLDOFF_US  = DEF_HOLDOFF_US,
    parameter int DIST_W      = DEF_DIST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              auto_en,
    input  logic              echo,
    output logic              trigger,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic              timeout,
    output logic [DIST_W-1:0] distance,
    output state_e            state_dbg
);

    localparam int CNT_W = cnt_width(TIMEOUT_US, HOLDOFF_US);

    state_e state_q, state_d;
    logic [CNT_W-1:0]  us_q, us_d;
    logic [CNT_W-1:0]  cm_us_q, cm_us_d;
    logic [DIST_W-1:0] cm_q, cm_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic echo_s1_q, echo_s2_q, echo_s3_q, rise_q, fall_q;
    logic trigger_q, done_q, valid_q, timeout_q;
    logic [DIST_W-1:0] distance_q;
    logic us_tick, hold_tick, tick_clr, hold_clr;

    // State-interval prescaler restarts on every state change; the holdoff one
    // restarts only at trigger rise so the cycle time is exact from that edge.
    assign tick_clr = (state_d != state_q);
    assign hold_clr = (state_d == TRIG) && (state_q != TRIG);

    hc_sr04_us_tick #(.CLKS_PER_US(CLKS_PER_US)) u_state_tick (
        .clk_i(clk), .rst_i(rst), .clr_i(tick_clr), .us_tick_o(us_tick)
    );

    hc_sr04_us_tick #(.CLKS_PER_US(CLKS_PER_US)) u_hold_tick (
        .clk_i(clk), .rst_i(rst), .clr_i(hold_clr), .us_tick_o(hold_tick)
    );

    // Counter next values: µs count, cm count (saturating), holdoff count (saturating at limit).
    always_comb begin
        us_d    = us_q;
        cm_us_d = cm_us_q;
        cm_d    = cm_q;
        hold_d  = hold_q;
        if (us_tick) begin
            us_d = us_q + 1'b1;
            if (cm_us_q == CNT_W'(US_PER_CM - 1)) begin
                cm_us_d = '0;
                if (cm_q != '1) begin
                    cm_d = cm_q + 1'b1;
                end
            end else begin
                cm_us_d = cm_us_q + 1'b1;
            end
        end
        if (hold_tick && (hold_q != CNT_W'(HOLDOFF_US))) begin
            hold_d = hold_q + 1'b1;
        end
    end

    // Next-state logic; counts include the tick of the current cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start || auto_en) state_d = TRIG;
            TRIG:      if (us_d == CNT_W'(TRIG_US)) state_d = WAIT_RISE;
            WAIT_RISE: begin
                if (rise_q) state_d = MEAS;
                else if (us_d == CNT_W'(TIMEOUT_US)) state_d = FAIL;
            end
            MEAS: begin
                if (fall_q) state_d = HOLD;
                else if (us_d == CNT_W'(TIMEOUT_US)) state_d = FAIL;
            end
            FAIL:      state_d = HOLD;
            HOLD: begin
                if (hold_d == CNT_W'(HOLDOFF_US)) state_d = auto_en ? TRIG : IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    // Echo synchroniser, registered edge detector, state, counters and output flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_s1_q  <= 1'b0;
            echo_s2_q  <= 1'b0;
            echo_s3_q  <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            state_q    <= IDLE;
            us_q       <= '0;
            cm_us_q    <= '0;
            cm_q       <= '0;
            hold_q     <= '0;
            trigger_q  <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            distance_q <= '0;
        end else begin
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
            echo_s3_q <= echo_s2_q;
            rise_q    <= echo_s2_q & ~echo_s3_q;
            fall_q    <= ~echo_s2_q & echo_s3_q;
            state_q   <= state_d;
            us_q      <= tick_clr ? '0 : us_d;
            cm_us_q   <= tick_clr ? '0 : cm_us_d;
            cm_q      <= tick_clr ? '0 : cm_d;
            hold_q    <= hold_clr ? '0 : hold_d;
            trigger_q <= (state_d == TRIG);
            done_q    <= (state_d == HOLD) && (state_q != HOLD);
            if (hold_clr) begin
                valid_q   <= 1'b0;
                timeout_q <= 1'b0;
            end else if ((state_q == MEAS) && (state_d == HOLD)) begin
                valid_q    <= 1'b1;
                distance_q <= cm_d;
            end else if ((state_d == FAIL) && (state_q != FAIL)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign trigger   = trigger_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign distance  = distance_q;
    assign state_dbg = state_q;

endmodule
